prach_fft_feeder: RTL

- Sits directly downstream of the PRACH buffer readout.
- Consumes its free-running complex sample stream (dr/di/dv plus a sync pulse marking symbol start) and frames it into fixed FFT_LEN blocks.
- Emits blocks on an AXI4-Stream master toward the FFT core, with tlast/tuser framing and backpressure.
- Only whole blocks are committed to the output; partial or overflowing blocks are discarded and flagged.

---
 rtl/prach_fft_feeder_if.sv | 21 ++
 rtl/prach_fft_feeder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/prach_fft_feeder_if.sv
// AXI4-Stream bundle carrying framed complex samples to the FFT core.
// tdata packs {imag, real} with the real part in the LSBs.
interface prach_fft_feeder_if #(
  parameter int DW = 16
);
  logic [2*DW-1:0] tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;
  logic            tuser;

  modport master (
    output tdata, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/prach_fft_feeder.sv
// Frames the PRACH sample stream into FFT_LEN blocks on AXI-Stream.
// Only complete blocks are committed; partial/overflowing ones are dropped.
module prach_fft_feeder #(
  parameter int FFT_LEN = 1536,
  parameter int ADDR_W  = 11,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din_dr,
  input  logic [DW-1:0] din_di,
  input  logic          din_dv,
  input  logic          sync_in,
  prach_fft_feeder_if.master m_axis,
  input  logic          stat_clr,
  output logic          stat_overflow,
  output logic          stat_misalign,
  output logic [15:0]   stat_blk_cnt
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int EW    = 2*DW + 2;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic [1:0] {
    WAIT_SYNC,
    FILL,
    DROP
  } wr_state_t;

  localparam ptr_t LAST = ptr_t'(FFT_LEN - 1);
  localparam ptr_t ONE  = ptr_t'(1);
  localparam ptr_t ROOM = ptr_t'(DEPTH - FFT_LEN);

  logic [1:0]      r_rst_sync;
  logic            w_rst;
  wr_state_t       r_state;
  logic            r_pend;
  ptr_t            r_wr_ptr;
  ptr_t            r_wr_commit;
  ptr_t            r_wr_k;
  logic            r_ovf;
  logic            r_mis;
  logic [2*DW-1:0] r_mem [DEPTH];
  logic [2*DW-1:0] r_rdata;
  ptr_t            r_rd_ptr;
  ptr_t            r_rd_k;
  logic            r_inflight;
  logic            r_inf_first;
  logic            r_inf_last;
  logic [1:0]      r_cnt;
  logic [EW-1:0]   r_e0;
  logic [EW-1:0]   r_e1;
  logic [15:0]     r_blk;

  logic            w_s0;
  logic            w_space_ok;
  logic            w_we;
  ptr_t            w_waddr;
  logic            w_pop;
  logic [1:0]      w_occ;
  logic            w_issue;
  logic [EW-1:0]   w_in;

  // Assert asynchronously, release two clocks later in the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rst_sync <= 2'b11;
    else     r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  assign w_s0       = din_dv && (sync_in || r_pend);
  assign w_space_ok = (r_wr_commit - r_rd_ptr) <= ROOM;
  assign w_we       = din_dv && (w_s0 ? w_space_ok
                                      : (r_state == FILL));
  assign w_waddr    = w_s0 ? r_wr_commit : r_wr_ptr;

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_state     <= WAIT_SYNC;
      r_pend      <= 1'b0;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_wr_k      <= '0;
      r_ovf       <= 1'b0;
      r_mis       <= 1'b0;
    end else begin
      if (din_dv)       r_pend <= 1'b0;
      else if (sync_in) r_pend <= 1'b1;
      if (stat_clr) begin
        r_ovf <= 1'b0;
        r_mis <= 1'b0;
      end
      if (w_s0) begin
        if (r_state == FILL) r_mis <= 1'b1;
        if (w_space_ok) begin
          r_state  <= FILL;
          r_wr_ptr <= r_wr_commit + ONE;
          r_wr_k   <= ONE;
        end else begin
          r_state  <= DROP;
          r_wr_ptr <= r_wr_commit;
          r_wr_k   <= '0;
          r_ovf    <= 1'b1;
        end
      end else if (din_dv && r_state == FILL) begin
        r_wr_ptr <= r_wr_ptr + ONE;
        if (r_wr_k == LAST) begin
          r_wr_commit <= r_wr_ptr + ONE;
          r_wr_k      <= '0;
          r_state     <= WAIT_SYNC;
        end else begin
          r_wr_k <= r_wr_k + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr[ADDR_W-1:0]] <= {din_di, din_dr};
    if (w_issue) r_rdata <= r_mem[r_rd_ptr[ADDR_W-1:0]];
  end

  // Issue a RAM read only if the skid pair can absorb it next cycle
  assign w_pop   = (r_cnt != 2'd0) && m_axis.tready;
  assign w_occ   = r_cnt + {1'b0, r_inflight};
  assign w_issue = (r_rd_ptr != r_wr_commit) &&
                   ((w_occ - {1'b0, w_pop}) < 2'd2);
  assign w_in    = {r_inf_last, r_inf_first, r_rdata};

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_rd_ptr    <= '0;
      r_rd_k      <= '0;
      r_inflight  <= 1'b0;
      r_inf_first <= 1'b0;
      r_inf_last  <= 1'b0;
      r_cnt       <= 2'd0;
      r_e0        <= '0;
      r_e1        <= '0;
      r_blk       <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + ONE;
        r_inf_first <= (r_rd_k == '0);
        r_inf_last  <= (r_rd_k == LAST);
        r_rd_k      <= (r_rd_k == LAST) ? '0 : r_rd_k + ONE;
      end
      unique case ({r_inflight, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_e0 <= w_in;
          else               r_e1 <= w_in;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_e0 <= w_in;
          end else begin
            r_e0 <= r_e1;
            r_e1 <= w_in;
          end
        end
        default: ;
      endcase
      if (stat_clr) r_blk <= '0;
      if (w_pop && r_e0[EW-1]) r_blk <= r_blk + 16'd1;
    end
  end

  assign m_axis.tvalid = (r_cnt != 2'd0);
  assign m_axis.tdata  = r_e0[2*DW-1:0];
  assign m_axis.tuser  = r_e0[2*DW];
  assign m_axis.tlast  = r_e0[2*DW+1];

  assign stat_overflow = r_ovf;
  assign stat_misalign = r_mis;
  assign stat_blk_cnt  = r_blk;

endmodule
